// File: rtl/tone_pkg.sv
// Shared types and constants for the square-wave tone detector.
package tone_pkg;

    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int unsigned DEF_HALF_1 = 113636;
    localparam int unsigned DEF_HALF_2 = 56818;
    localparam int unsigned DEF_HALF_3 = 227272;

    typedef enum logic [1:0] {
        SND_NONE = 2'd0,
        SND_1    = 2'd1,
        SND_2    = 2'd2,
        SND_3    = 2'd3
    } snd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Inclusive absolute-distance test against a nominal half-period.
    function automatic logic within_tol(input logic [CNT_W-1:0] h,
                                        input int unsigned nom,
                                        input int unsigned tol);
        int unsigned hv;
        hv = 32'(h);
        if (hv >= nom) return (hv - nom) <= tol;
        return (nom - hv) <= tol;
    endfunction

    // Lowest matching class wins when tolerance windows overlap.
    function automatic snd_t classify(input logic [CNT_W-1:0] h,
                                      input int unsigned h1,
                                      input int unsigned h2,
                                      input int unsigned h3,
                                      input int unsigned tol);
        if (within_tol(h, h1, tol)) return SND_1;
        if (within_tol(h, h2, tol)) return SND_2;
        if (within_tol(h, h3, tol)) return SND_3;
        return SND_NONE;
    endfunction

endpackage

// File: rtl/tone_detector_edge_sync.sv
// Two-flop synchronizer for the async audio line plus any-edge detection.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic edge_pulse
);

    logic [1:0] sync_q;
    logic       dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_async};
            dly_q  <= sync_q[1];
        end
    end

    assign edge_pulse = sync_q[1] ^ dly_q;

endmodule

// File: rtl/tone_detector.sv
// Measures audio half-periods, classifies them and locks onto a tone after
// MATCH consecutive same-class measurements; drops to silence on timeout.
module tone_detector
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned HALF_1  = DEF_HALF_1,
    parameter int unsigned HALF_2  = DEF_HALF_2,
    parameter int unsigned HALF_3  = DEF_HALF_3,
    parameter int unsigned TOL     = 2048,
    parameter int unsigned MATCH   = 4,
    parameter int unsigned TIMEOUT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             audio_in,
    output logic [1:0]       sound_type,
    output logic             sound_valid,
    output logic             sound_change,
    output logic [CNT_W-1:0] half_period
);

    localparam int unsigned STRK_W = $clog2(MATCH + 1);

    if (CLK_HZ == 0 || MATCH == 0 || TIMEOUT > 32'(CNT_MAX)) begin : g_bad_params
        $error("tone_detector: invalid parameter set");
    end

    logic              edge_pulse;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  meas_h;
    snd_t              meas_cls;
    logic              timeout;

    state_t            state_q, state_d;
    snd_t              snd_q, snd_d;
    snd_t              scls_q, scls_d;
    logic [STRK_W-1:0] strk_q, strk_d;
    logic              valid_q, valid_d;
    logic              chg_q, chg_d;
    logic [CNT_W-1:0]  hp_q, hp_d;

    edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .d_async    (audio_in),
        .edge_pulse (edge_pulse)
    );

    // Cycles since last edge, saturating.
    always_ff @(posedge clk) begin
        if (rst)                  cnt_q <= '0;
        else if (edge_pulse)      cnt_q <= '0;
        else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign meas_h   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    assign meas_cls = classify(meas_h, HALF_1, HALF_2, HALF_3, TOL);
    assign timeout  = !edge_pulse && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            snd_q   <= SND_NONE;
            scls_q  <= SND_NONE;
            strk_q  <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            hp_q    <= '0;
        end else begin
            state_q <= state_d;
            snd_q   <= snd_d;
            scls_q  <= scls_d;
            strk_q  <= strk_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            hp_q    <= hp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snd_d   = snd_q;
        scls_d  = scls_q;
        strk_d  = strk_q;
        valid_d = valid_q;
        chg_d   = 1'b0;
        hp_d    = hp_q;

        case (state_q)
            ST_IDLE: begin
                // First edge only arms the reference.
                if (edge_pulse) begin
                    state_d = ST_TRACK;
                    strk_d  = '0;
                    scls_d  = SND_NONE;
                end
            end
            ST_TRACK, ST_LOCKED: begin
                if (edge_pulse) begin
                    hp_d = meas_h;
                    if (meas_cls == SND_NONE) begin
                        strk_d = '0;
                        scls_d = SND_NONE;
                    end else if (meas_cls == scls_q && strk_q != '0) begin
                        if (strk_q != STRK_W'(MATCH)) strk_d = strk_q + STRK_W'(1);
                    end else begin
                        strk_d = STRK_W'(1);
                        scls_d = meas_cls;
                    end
                    if (meas_cls != SND_NONE && strk_d == STRK_W'(MATCH) && meas_cls != snd_q) begin
                        snd_d   = meas_cls;
                        valid_d = 1'b1;
                        chg_d   = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    snd_d   = SND_NONE;
                    valid_d = 1'b0;
                    chg_d   = (snd_q != SND_NONE);
                    strk_d  = '0;
                    scls_d  = SND_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sound_type   = snd_q;
    assign sound_valid  = valid_q;
    assign sound_change = chg_q;
    assign half_period  = hp_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector with shortened half-periods and timeout.
module tb_tone_detector;
    import tone_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        audio_in = 1'b0;
    logic [1:0]  sound_type;
    logic        sound_valid;
    logic        sound_change;
    logic [19:0] half_period;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int base;

    tone_detector #(
        .CLK_HZ  (100000000),
        .HALF_1  (100),
        .HALF_2  (50),
        .HALF_3  (200),
        .TOL     (4),
        .MATCH   (4),
        .TIMEOUT (500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_in     (audio_in),
        .sound_type   (sound_type),
        .sound_valid  (sound_valid),
        .sound_change (sound_change),
        .half_period  (half_period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sound_change === 1'b1) pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tog();
        audio_in = ~audio_in;
    endtask

    task automatic gap(input int n);
        wait_cyc(n);
        tog();
    endtask

    task automatic do_reset();
        audio_in = 1'b0;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_type",   32'(sound_type), 0);
        check("rst_valid",  32'(sound_valid), 0);
        check("rst_change", 32'(sound_change), 0);
        check("rst_hp",     32'(half_period), 0);
        check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        wait_cyc(2);

        // 102-cycle half-periods: lock on the 5th edge
        base = pulse_cnt;
        tog();
        gap(102); gap(102); gap(102);
        wait_cyc(102);
        check("t1_prelock_type", 32'(sound_type), 0);
        tog();
        wait_cyc(102);
        check("t1_lock_type",  32'(sound_type), 1);
        check("t1_lock_valid", 32'(sound_valid), 1);
        check("t1_lock_hp",    32'(half_period), 102);
        check("t1_pulses",     32'(pulse_cnt - base), 1);
        tog();

        // Switch to 50-cycle half-periods: type 1 held for 3 measurements
        base = pulse_cnt;
        gap(50); gap(50); gap(50);
        wait_cyc(50);
        check("t2_hold_type", 32'(sound_type), 1);
        check("t2_hold_hp",   32'(half_period), 50);
        tog();
        wait_cyc(50);
        check("t2_switch_type",  32'(sound_type), 2);
        check("t2_switch_valid", 32'(sound_valid), 1);
        check("t2_pulses",       32'(pulse_cnt - base), 1);

        // One-cycle reset while locked
        base = pulse_cnt;
        rst = 1'b1;
        wait_cyc(1);
        check("t3_type",   32'(sound_type), 0);
        check("t3_valid",  32'(sound_valid), 0);
        check("t3_change", 32'(sound_change), 0);
        check("t3_hp",     32'(half_period), 0);
        check("t3_state",  32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        wait_cyc(3);
        check("t3_pulses", 32'(pulse_cnt - base), 0);

        // 100,100,100,150 clears the streak; four more 100s needed
        tog();
        gap(100); gap(100); gap(100); gap(150);
        wait_cyc(100);
        check("t4_after150_type", 32'(sound_type), 0);
        check("t4_after150_hp",   32'(half_period), 150);
        tog(); gap(100); gap(100);
        wait_cyc(100);
        check("t4_three_type", 32'(sound_type), 0);
        tog();
        wait_cyc(100);
        check("t4_lock_type", 32'(sound_type), 1);

        // Boundaries 104/96 classify as type 1
        do_reset();
        tog();
        gap(104); gap(96); gap(104); gap(96);
        wait_cyc(20);
        check("t5_in_type", 32'(sound_type), 1);
        check("t5_in_hp",   32'(half_period), 96);

        // 105 falls outside the window
        do_reset();
        tog();
        gap(100); gap(100); gap(100); gap(105);
        wait_cyc(20);
        check("t6_105_type", 32'(sound_type), 0);
        check("t6_105_hp",   32'(half_period), 105);

        // 95 falls outside the window
        do_reset();
        tog();
        gap(100); gap(100); gap(100); gap(95);
        wait_cyc(20);
        check("t7_95_type", 32'(sound_type), 0);
        check("t7_95_hp",   32'(half_period), 95);

        // Type 3 lock then silence
        do_reset();
        tog();
        gap(200); gap(200); gap(200); gap(200);
        wait_cyc(20);
        check("t8_lock_type",  32'(sound_type), 3);
        check("t8_lock_valid", 32'(sound_valid), 1);
        base = pulse_cnt;
        wait_cyc(380);
        check("t8_before_to_type", 32'(sound_type), 3);
        wait_cyc(150);
        check("t8_to_type",   32'(sound_type), 0);
        check("t8_to_valid",  32'(sound_valid), 0);
        check("t8_to_pulses", 32'(pulse_cnt - base), 1);
        check("t8_to_state",  32'(dut.state_q), 32'(ST_IDLE));
        tog();
        wait_cyc(20);
        check("t8_arm_hp",    32'(half_period), 200);
        check("t8_arm_state", 32'(dut.state_q), 32'(ST_TRACK));
        check("t8_arm_type",  32'(sound_type), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
